// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and RAM port 2.
// One request at a time: alignment check, RAM handshake, timeout, one-cycle response.
module load_store_unit #(
  parameter int unsigned TIMEOUT     = 15,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_mode,
  input  logic        req_signed,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        port2en,
  output logic        wrEn,
  output logic [31:0] port2adr,
  output logic [31:0] port2i,
  output logic [1:0]  memMode,
  input  logic [31:0] port2o,
  input  logic        port2avail,
  input  logic        iRegAvail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WLOAD,
    S_WSTORE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  mode_q, mode_d;
  logic        sgn_q, sgn_d;
  logic        mis_q, mis_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        misaligned;
  logic [31:0] ext;
  logic [8:0]  cnt_inc;
  logic        timed_out;

  always_comb begin
    misaligned = (req_mode == 2'd3);
    if (ALIGN_CHECK) begin
      misaligned = misaligned
        | (req_mode == 2'd1 && req_addr[0])
        | (req_mode == 2'd0 && req_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    ext = port2o;
    if (sgn_q && mode_q == 2'd2) begin
      ext = {{24{port2o[7]}}, port2o[7:0]};
    end else if (sgn_q && mode_q == 2'd1) begin
      ext = {{16{port2o[15]}}, port2o[15:0]};
    end
  end

  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
  assign timed_out = (cnt_inc >= 9'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mode_d    = mode_q;
    sgn_d     = sgn_q;
    mis_d     = mis_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    req_ready = 1'b0;
    port2en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          mode_d  = req_mode;
          sgn_d   = req_signed;
          mis_d   = misaligned;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A rejected request spends its ISSUE cycle without touching RAM
        if (mis_q) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          port2en = 1'b1;
          if (iRegAvail) begin
            cnt_d   = '0;
            state_d = we_q ? S_WSTORE : S_WLOAD;
          end
        end
      end
      S_WLOAD: begin
        if (port2avail) begin
          fault_d = 1'b0;
          rdata_d = ext;
          state_d = S_RESP;
        end else if (timed_out) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      S_WSTORE: begin
        if (iRegAvail) begin
          fault_d = 1'b0;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (timed_out) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      sgn_q   <= sgn_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = rdata_q;
  assign wrEn       = we_q;
  assign port2adr   = addr_q;
  assign port2i     = wdata_q;
  assign memMode    = mode_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM port-2 model, vector table,
// random ops against a byte-array reference model, timeout and reset cases.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_mode = '0;
  logic        req_signed = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        port2en;
  logic        wrEn;
  logic [31:0] port2adr;
  logic [31:0] port2i;
  logic [1:0]  memMode;
  logic [31:0] port2o;
  logic        port2avail;
  logic        iRegAvail;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(15), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mode(req_mode),
    .req_signed(req_signed), .busy(busy),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .port2en(port2en),
    .wrEn(wrEn), .port2adr(port2adr), .port2i(port2i),
    .memMode(memMode), .port2o(port2o),
    .port2avail(port2avail), .iRegAvail(iRegAvail)
  );

  always #5 clk = ~clk;

  // RAM port-2 model: load answers next cycle, store is READ then REWRITE
  logic [7:0]  ram [0:255];
  int          ram_st;
  logic        p2avail_q;
  logic [31:0] p2o_q;
  logic        stub = 1'b0;
  logic [7:0]  wa;

  assign iRegAvail  = (ram_st == 0) && (!stub || port2en);
  assign port2avail = p2avail_q;
  assign port2o     = p2o_q;

  function automatic logic [31:0] ram_rd(input logic [31:0] a,
                                         input logic [1:0] m);
    logic [7:0] i;
    i = a[7:0];
    if (m == 2'd0) begin
      i[1:0] = 2'b00;
      return {ram[i+8'd3], ram[i+8'd2], ram[i+8'd1], ram[i]};
    end else if (m == 2'd1) begin
      i[0] = 1'b0;
      return {16'h0, ram[i+8'd1], ram[i]};
    end
    return {24'h0, ram[i]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_st    <= 0;
      p2avail_q <= 1'b0;
      p2o_q     <= '0;
    end else begin
      p2avail_q <= 1'b0;
      if (ram_st == 0) begin
        if (port2en && !stub) begin
          if (wrEn) ram_st <= 1;
          else begin
            p2avail_q <= 1'b1;
            p2o_q     <= ram_rd(port2adr, memMode);
          end
        end
      end else if (ram_st == 1) begin
        ram_st <= 2;
      end else begin
        wa = port2adr[7:0];
        if (memMode == 2'd0) begin
          wa[1:0] = 2'b00;
          ram[wa]      <= port2i[7:0];
          ram[wa+8'd1] <= port2i[15:8];
          ram[wa+8'd2] <= port2i[23:16];
          ram[wa+8'd3] <= port2i[31:24];
        end else if (memMode == 2'd1) begin
          wa[0] = 1'b0;
          ram[wa]      <= port2i[7:0];
          ram[wa+8'd1] <= port2i[15:8];
        end else begin
          ram[wa] <= port2i[7:0];
        end
        ram_st <= 0;
      end
    end
  end

  // Reference model: byte array plus arithmetic extension rules
  logic [7:0] ref_mem [0:255];

  function automatic int nbytes(input logic [1:0] m);
    return (m == 2'd0) ? 4 : (m == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic ref_mis(input logic [1:0] m, input int a);
    return (m == 2'd3) || (m == 2'd1 && a % 2 != 0)
        || (m == 2'd0 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input int a,
                                           input logic [1:0] m,
                                           input logic s);
    longint v;
    int n;
    v = 0;
    n = nbytes(m);
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[(a + i) & 255]) << (8 * i);
    if (s && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input int a, input logic [1:0] m,
                           input logic [31:0] d);
    int n;
    n = nbytes(m);
    for (int i = 0; i < n; i++)
      ref_mem[(a + i) & 255] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] m,
                     input logic s, output logic [31:0] rd,
                     output logic f, output int edges,
                     output int p2, output logic wseen);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd;
    req_mode = m; req_signed = s; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 0; p2 = 0; wseen = 1'b0;
    while (!resp_valid && edges < 200) begin
      if (port2en) p2++;
      if (wrEn) wseen = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    rd = resp_rdata;
    f  = resp_fault;
  endtask

  task automatic op(input logic we, input int a, input logic [31:0] wd,
                    input logic [1:0] m, input logic s, input string tag);
    logic [31:0] rd, exp_rd;
    logic f, exp_f, ws;
    int e, p2, exp_e;
    exp_f  = ref_mis(m, a);
    exp_rd = '0;
    exp_e  = exp_f ? 1 : (we ? 4 : 2);
    if (!exp_f && !we) exp_rd = ref_load(a, m, s);
    run(we, 32'(a), wd, m, s, rd, f, e, p2, ws);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " fault"}, 32'(f), 32'(exp_f));
    chk({tag, " edges"}, 32'(e), 32'(exp_e));
    if (!exp_f && we) ref_store(a, m, wd);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mode;
    logic        sgn;
    logic [31:0] exp_rd;
    logic        exp_f;
    int          exp_e;
    int          exp_p2;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] rd;
    logic f, ws;
    int e, p2, n, resps, rv;
    logic [7:0] b;

    tbl[0]  = '{1'b0, 32'h100, 32'h0,  2'd0, 1'b0, 32'h8081F0F7, 1'b0, 2, 1};
    tbl[1]  = '{1'b0, 32'h100, 32'h0,  2'd2, 1'b1, 32'hFFFFFFF7, 1'b0, 2, 1};
    tbl[2]  = '{1'b0, 32'h102, 32'h0,  2'd2, 1'b0, 32'h00000081, 1'b0, 2, 1};
    tbl[3]  = '{1'b0, 32'h102, 32'h0,  2'd1, 1'b1, 32'hFFFF8081, 1'b0, 2, 1};
    tbl[4]  = '{1'b0, 32'h102, 32'h0,  2'd1, 1'b0, 32'h00008081, 1'b0, 2, 1};
    tbl[5]  = '{1'b1, 32'h101, 32'hAA, 2'd2, 1'b0, 32'h0,        1'b0, 4, 1};
    tbl[6]  = '{1'b0, 32'h100, 32'h0,  2'd0, 1'b0, 32'h8081AAF7, 1'b0, 2, 1};
    tbl[7]  = '{1'b0, 32'h103, 32'h0,  2'd1, 1'b0, 32'h0,        1'b1, 1, 0};
    tbl[8]  = '{1'b0, 32'h102, 32'h0,  2'd0, 1'b0, 32'h0,        1'b1, 1, 0};
    tbl[9]  = '{1'b0, 32'h100, 32'h0,  2'd3, 1'b0, 32'h0,        1'b1, 1, 0};
    tbl[10] = '{1'b1, 32'h101, 32'h5,  2'd0, 1'b0, 32'h0,        1'b1, 1, 0};

    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      ram[i] = b;
      ref_mem[i] = b;
    end
    ram[8'h00] = 8'hF7; ram[8'h01] = 8'hF0;
    ram[8'h02] = 8'h81; ram[8'h03] = 8'h80;
    ref_store(32'h100, 2'd0, 32'h8081F0F7);

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst port2en", 32'(port2en), 32'd0);
    chk("rst resp", {resp_valid, resp_fault, resp_rdata[29:0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mode,
          tbl[i].sgn, rd, f, e, p2, ws);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d fault", i), 32'(f), 32'(tbl[i].exp_f));
      chk($sformatf("vec%0d edges", i), 32'(e), 32'(tbl[i].exp_e));
      chk($sformatf("vec%0d port2en", i), 32'(p2), 32'(tbl[i].exp_p2));
      chk($sformatf("vec%0d wrEn", i), 32'(ws), 32'(tbl[i].we));
      @(posedge clk); #1;
      chk($sformatf("vec%0d pulse", i), 32'(resp_valid), 32'd0);
      if (tbl[i].we && !tbl[i].exp_f)
        ref_store(int'(tbl[i].addr), tbl[i].mode, tbl[i].wdata);
    end

    for (int i = 0; i < 40; i++) begin
      int a;
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      a = 32'h100 + int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (m == 2'd0) a = a & ~3;
        if (m == 2'd1) a = a & ~1;
      end
      op($urandom_range(0, 2) == 0, a, $urandom, m,
         1'($urandom), $sformatf("rnd%0d", i));
    end

    stub = 1'b1;
    run(1'b0, 32'h104, 32'h0, 2'd0, 1'b0, rd, f, e, p2, ws);
    chk("timeout fault", 32'(f), 32'd1);
    chk("timeout rdata", rd, 32'd0);
    chk("timeout edges", 32'(e), 32'd16);
    stub = 1'b0;

    op(1'b0, 32'h100, 32'h0, 2'd0, 1'b0, "pre_reset");
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h108; req_wdata = 32'h12345678;
    req_mode = 2'd0; req_signed = 1'b0; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid store busy", 32'(busy), 32'd1);
    chk("mid store wrEn", 32'(wrEn), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("areset busy", 32'(busy), 32'd0);
    chk("areset ready", 32'(req_ready), 32'd1);
    chk("areset p2en_wrEn", {port2en, wrEn}, 32'd0);
    chk("areset port2adr", port2adr, 32'd0);
    chk("areset port2i", port2i, 32'd0);
    chk("areset memMode", 32'(memMode), 32'd0);
    chk("areset resp", {resp_valid, resp_fault}, 32'd0);
    chk("areset rdata", resp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (resp_valid) rv++;
    end
    chk("no resp after abort", 32'(rv), 32'd0);
    op(1'b0, 32'h108, 32'h0, 2'd0, 1'b0, "aborted store");

    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h100; req_mode = 2'd0;
    req_signed = 1'b0; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    resps = 0; p2 = 0;
    for (int i = 0; i < 12; i++) begin
      if (port2en) p2++;
      @(posedge clk); #1;
      if (resp_valid) begin
        resps++;
        chk($sformatf("b2b rdata%0d", resps), resp_rdata,
            ref_load(32'h100, 2'd0, 1'b0));
      end
    end
    req_valid = 1'b0;
    chk("b2b responses", 32'(resps), 32'd3);
    chk("b2b port2en", 32'(p2), 32'd3);
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b drain", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
